// File: rtl/dfd_debug_signal_delay_line.sv
// dfd_debug_signal_delay_line
// Per-lane programmable delay line for the CLA debug bus. Each lane owns a
// MAX_DELAY-deep tap chain, a saturating history counter and a freeze
// control; a global flush clears every lane.
// Optional build macro: DFD_DEBUG_DELAY_OUTPUT_FLOP_EN registers both
// outputs, adding one cycle of latency to every lane.
module dfd_debug_signal_delay_line #(
  parameter int unsigned DEBUG_MUX_OUTPUT_WIDTH = 64,
  parameter int unsigned LANE_WIDTH             = 8,
  parameter int unsigned NUM_OUTPUT_LANES       = DEBUG_MUX_OUTPUT_WIDTH / LANE_WIDTH,
  parameter int unsigned MAX_DELAY              = 8,
  parameter int unsigned DELAY_SEL_WIDTH        = $clog2(MAX_DELAY + 1)
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic [DEBUG_MUX_OUTPUT_WIDTH-1:0]            debug_signals_in,
  input  logic [NUM_OUTPUT_LANES*DELAY_SEL_WIDTH-1:0]  delay_sel,
  input  logic [NUM_OUTPUT_LANES-1:0]                  lane_freeze,
  input  logic                                         flush,
  output logic [DEBUG_MUX_OUTPUT_WIDTH-1:0]            debug_signals_out,
  output logic [NUM_OUTPUT_LANES-1:0]                  lane_valid
);

  localparam logic [DELAY_SEL_WIDTH-1:0] MAX_D = DELAY_SEL_WIDTH'(MAX_DELAY);

  logic [LANE_WIDTH-1:0]             lane_in   [NUM_OUTPUT_LANES];
  logic [LANE_WIDTH-1:0]             taps      [NUM_OUTPUT_LANES][1:MAX_DELAY];
  logic [DELAY_SEL_WIDTH-1:0]        hist      [NUM_OUTPUT_LANES];
  logic [DELAY_SEL_WIDTH-1:0]        eff_delay [NUM_OUTPUT_LANES];
  logic [DEBUG_MUX_OUTPUT_WIDTH-1:0] out_comb;
  logic [NUM_OUTPUT_LANES-1:0]       valid_comb;

  // Unpack input lanes and clamp each lane's delay select to MAX_DELAY.
  always_comb begin
    for (int unsigned i = 0; i < NUM_OUTPUT_LANES; i++) begin
      lane_in[i] = debug_signals_in[i*LANE_WIDTH +: LANE_WIDTH];
      eff_delay[i] = delay_sel[i*DELAY_SEL_WIDTH +: DELAY_SEL_WIDTH];
      if (eff_delay[i] > MAX_D) begin
        eff_delay[i] = MAX_D;
      end
    end
  end

  // Tap chains and history counters; flush beats freeze, freeze holds a lane.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_OUTPUT_LANES; i++) begin
        hist[i] <= '0;
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
          taps[i][k] <= '0;
        end
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_OUTPUT_LANES; i++) begin
        hist[i] <= '0;
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
          taps[i][k] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_OUTPUT_LANES; i++) begin
        if (!lane_freeze[i]) begin
          taps[i][1] <= lane_in[i];
          for (int unsigned k = 2; k <= MAX_DELAY; k++) begin
            taps[i][k] <= taps[i][k-1];
          end
          if (hist[i] != MAX_D) begin
            hist[i] <= hist[i] + DELAY_SEL_WIDTH'(1);
          end
        end
      end
    end
  end

  // Output mux: delay 0 passes the live lane, delay k selects tap k.
  always_comb begin
    out_comb   = '0;
    valid_comb = '0;
    for (int unsigned i = 0; i < NUM_OUTPUT_LANES; i++) begin
      if (eff_delay[i] == '0) begin
        out_comb[i*LANE_WIDTH +: LANE_WIDTH] = lane_in[i];
      end
      for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
        if (eff_delay[i] == DELAY_SEL_WIDTH'(k)) begin
          out_comb[i*LANE_WIDTH +: LANE_WIDTH] = taps[i][k];
        end
      end
      valid_comb[i] = (hist[i] >= eff_delay[i]);
    end
  end

`ifdef DFD_DEBUG_DELAY_OUTPUT_FLOP_EN
  // Registered outputs: one extra cycle on every lane, cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      debug_signals_out <= '0;
      lane_valid        <= '0;
    end else begin
      debug_signals_out <= out_comb;
      lane_valid        <= valid_comb;
    end
  end
`else
  // Combinational outputs straight from the mux.
  always_comb begin
    debug_signals_out = out_comb;
    lane_valid        = valid_comb;
  end
`endif

endmodule
